// File: rtl/debounce_event_arbiter.sv
// debounce_event_arbiter: serialises per-channel debouncer transition pulses into one
// round-robin event stream presented on a valid/ready output register.
// Ports:
//   i_clk, i_reset        clock and synchronous active-high reset
//   i_trans_up/dn[N_CH]   one-cycle transition pulses per channel (up wins if both)
//   o_ev_valid, i_ev_ready, o_ev_chan, o_ev_up   event output handshake
//   o_overrun[N_CH], i_overrun_clr              sticky lost-event flags and clear
// Optional feature: define ARB_OVERRUN_EN to build the overrun flags; otherwise
// o_overrun is tied to 0 and i_overrun_clr is ignored.
module debounce_event_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_CH-1:0]  i_trans_up,
    input  logic [N_CH-1:0]  i_trans_dn,
    output logic             o_ev_valid,
    input  logic             i_ev_ready,
    output logic [IDX_W-1:0] o_ev_chan,
    output logic             o_ev_up,
    output logic [N_CH-1:0]  o_overrun,
    input  logic             i_overrun_clr
);
    logic [N_CH-1:0]  r_pend;
    logic [N_CH-1:0]  r_dir;
    logic [IDX_W-1:0] r_ptr;
    logic             r_valid;
    logic [IDX_W-1:0] r_chan;
    logic             r_up;
    logic [N_CH-1:0]  w_ev;
    logic [N_CH-1:0]  w_gnt;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_nxt;
    logic [IDX_W:0]   w_pos;
    logic             w_any;
    logic             w_load;

    assign w_ev   = i_trans_up | i_trans_dn;
    assign w_load = !r_valid || i_ev_ready;
    assign w_nxt  = (w_win == IDX_W'(N_CH - 1)) ? '0 : w_win + 1'b1;
    assign w_gnt  = (w_load && w_any) ? (N_CH'(1) << w_win) : '0;

    // Scan from the farthest offset back to ptr so the nearest pending channel wins.
    always_comb begin
        w_win = '0;
        w_pos = '0;
        w_any = |r_pend;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_pos = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_pos >= (IDX_W+1)'(N_CH)) w_pos = w_pos - (IDX_W+1)'(N_CH);
            if (r_pend[w_pos[IDX_W-1:0]]) w_win = w_pos[IDX_W-1:0];
        end
    end

    // A new pulse re-arms pend even on the channel being granted this cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend  <= '0;
            r_dir   <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_chan  <= '0;
            r_up    <= 1'b0;
        end else begin
            r_pend <= w_ev | (r_pend & ~w_gnt);
            r_dir  <= (w_ev & i_trans_up) | (~w_ev & r_dir);
            if (w_load) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_chan <= w_win;
                    r_up   <= r_dir[w_win];
                    r_ptr  <= w_nxt;
                end
            end
        end
    end

    assign o_ev_valid = r_valid;
    assign o_ev_chan  = r_chan;
    assign o_ev_up    = r_up;

`ifdef ARB_OVERRUN_EN
    logic [N_CH-1:0] r_ovr;
    // A fresh overwrite beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_ovr <= '0;
        else r_ovr <= (w_ev & r_pend & ~w_gnt) | (i_overrun_clr ? '0 : r_ovr);
    end
    assign o_overrun = r_ovr;
`else
    logic w_unused;
    assign w_unused  = i_overrun_clr;
    assign o_overrun = '0;
`endif
endmodule
